// File: rtl/dm_resp.sv
// Data-memory responder: req/busy/done handshake, WAIT_CYC wait states, byte-lane writes.
// Optional alignment checking of accesses is enabled by defining DM_ALIGN_CHK_EN.
module dm_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned IdxW     = ADDR_W - 2;
  localparam int unsigned Depth    = 2 ** IdxW;
  localparam logic [3:0]  WaitInit = WAIT_CYC[3:0];

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              latch;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;
  logic              ok;
  logic [IdxW-1:0]   idx;

  // Not touched by rst; only the time-0 contents are defined.
  logic [31:0] mem_q [Depth] = '{default: 32'h0};

  assign idx   = addr_q[ADDR_W-1:2];
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          latch   = 1'b1;
          cnt_d   = WaitInit;
          state_d = (WAIT_CYC > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && latch) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

`ifdef DM_ALIGN_CHK_EN
  logic err_q;

  always_comb begin
    ok = 1'b0;
    if (!we_q) begin
      ok = (addr_q[1:0] == 2'd0);
    end else begin
      case (be_q)
        4'b0000: ok = 1'b1;
        4'b0001: ok = (addr_q[1:0] == 2'd0);
        4'b0010: ok = (addr_q[1:0] == 2'd1);
        4'b0100: ok = (addr_q[1:0] == 2'd2);
        4'b1000: ok = (addr_q[1:0] == 2'd3);
        4'b0011: ok = (addr_q[1:0] == 2'd0);
        4'b1100: ok = (addr_q[1:0] == 2'd2);
        4'b1111: ok = (addr_q[1:0] == 2'd0);
        default: ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StAccess) begin
      err_q <= !ok;
    end
  end

  assign err = err_q;
`else
  logic unused_lsb;

  assign unused_lsb = ^addr_q[1:0];
  assign ok         = 1'b1;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (state_q == StAccess && !we_q) begin
      rdata_q <= ok ? mem_q[idx] : 32'h0;
    end
  end

  // rst has priority: a write whose ACCESS edge sees rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StAccess && we_q && ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: scoreboard of expected rdata/err per transaction,
// a WAIT_CYC=2 instance for the main scenarios and a WAIT_CYC=0 instance for back-to-back.
module tb_dm_resp;

  localparam int unsigned WaitCyc = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        busy, done, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [9:0]  addr0;
  logic [31:0] wdata0;
  logic [3:0]  be0;
  logic        busy0, done0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  exp_t        sb0[$];
  logic [31:0] model_mem [256];
  logic [31:0] last_rd;
  logic [31:0] top_val0;
  logic [31:0] last_rd0;

  always #5 clk = ~clk;

  dm_resp #(.ADDR_W(10), .WAIT_CYC(WaitCyc)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  dm_resp #(.ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .busy(busy0), .done(done0), .rdata(rdata0), .err(err0)
  );

  function automatic logic legal(input logic w, input logic [9:0] a, input logic [3:0] b);
    logic ok;
    if (!w) begin
      ok = (a[1:0] == 2'd0);
    end else begin
      case (b)
        4'b0000: ok = 1'b1;
        4'b0001: ok = (a[1:0] == 2'd0);
        4'b0010: ok = (a[1:0] == 2'd1);
        4'b0100: ok = (a[1:0] == 2'd2);
        4'b1000: ok = (a[1:0] == 2'd3);
        4'b0011: ok = (a[1:0] == 2'd0);
        4'b1100: ok = (a[1:0] == 2'd2);
        4'b1111: ok = (a[1:0] == 2'd0);
        default: ok = 1'b0;
      endcase
    end
`ifndef DM_ALIGN_CHK_EN
    ok = 1'b1;
`endif
    return ok;
  endfunction

  task automatic model_push(input logic w, input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    exp_t e;
    logic ok;
    int   idx;
    ok  = legal(w, a, b);
    idx = int'(a[9:2]);
    if (w) begin
      if (ok) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      last_rd = ok ? model_mem[idx] : 32'h0;
    end
    e.rdata = last_rd;
    e.err   = !ok;
    sb.push_back(e);
  endtask

  task automatic txn(input logic w, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] b, input string name);
    exp_t e;
    int   n;
    model_push(w, a, d, b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; only latched values may matter.
    req = 1'b0; we = 1'($urandom); addr = 10'($urandom); wdata = $urandom;
    be = 4'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b want 1 (cycle %0d)", name, busy, n);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== WaitCyc + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, WaitCyc + 1);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rdata !== e.rdata) begin
        errors++;
        $display("FAIL %s rdata: got %h want %h", name, rdata, e.rdata);
      end
      checks++;
      if (err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b want %b", name, err, e.err);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b want 1", name, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd  = 32'h0;
    last_rd0 = 32'h0;
    checks++;
    if ({busy, done, err, rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b err=%b rdata=%h want 0 0 0 0",
               busy, done, err, rdata);
    end
    checks++;
    if ({busy0, done0, err0, rdata0} !== 35'h0) begin
      errors++;
      $display("FAIL reset0: got busy=%b done=%b err=%b rdata=%h want 0 0 0 0",
               busy0, done0, err0, rdata0);
    end
    txn(1'b0, 10'h000, 32'h0, 4'hf, "rd_word0");
  endtask

  task automatic test_word_rw();
    txn(1'b1, 10'h010, 32'hDEADBEEF, 4'b1111, "wr_word");
    txn(1'b0, 10'h010, 32'h0, 4'b0000, "rd_word");
  endtask

  task automatic test_byte_write();
    txn(1'b1, 10'h013, 32'h5A000000, 4'b1000, "wr_byte3");
    txn(1'b0, 10'h010, 32'h0, 4'b1111, "rd_byte3");
    txn(1'b1, 10'h010, 32'h00000011, 4'b0001, "wr_byte0");
    txn(1'b1, 10'h012, 32'h77660000, 4'b1100, "wr_half1");
    txn(1'b0, 10'h010, 32'h0, 4'b1111, "rd_mixed");
  endtask

  task automatic test_zero_be();
    txn(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, "wr_be0");
    txn(1'b0, 10'h010, 32'h0, 4'b0000, "rd_be0");
    txn(1'b1, 10'h3FC, 32'hC0DEC0DE, 4'b1111, "wr_top");
    txn(1'b0, 10'h3FC, 32'h0, 4'b0000, "rd_top");
  endtask

  task automatic test_reset_in_access();
    txn(1'b1, 10'h020, 32'hCAFEF00D, 4'b1111, "wr_prior");
    req = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'h12345678; be = 4'b1111;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_access pre: got busy=%b done=%b want 1 0", busy, done);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, rdata} !== 34'h0) begin
      errors++;
      $display("FAIL rst_access post: got busy=%b done=%b rdata=%h want 0 0 0",
               busy, done, rdata);
    end
    rst = 1'b0;
    last_rd  = 32'h0;
    last_rd0 = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_access no_done: got %b want 0", done);
    end
    txn(1'b0, 10'h020, 32'h0, 4'b0000, "rd_after_rst");
  endtask

  task automatic test_align();
    txn(1'b1, 10'h022, 32'h11112222, 4'b1111, "wr_misalign");
    txn(1'b0, 10'h021, 32'h0, 4'b0000, "rd_misalign");
    txn(1'b0, 10'h020, 32'h0, 4'b0000, "rd_aligned");
  endtask

  task automatic set0(input logic w, input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    we0 = w; addr0 = a; wdata0 = d; be0 = 4'b1111; req0 = 1'b1;
    if (w) begin
      if (a == 10'h3FC) top_val0 = d;
    end else begin
      last_rd0 = (a == 10'h3FC) ? top_val0 : 32'h0;
    end
    e.rdata = last_rd0;
    e.err   = 1'b0;
    sb0.push_back(e);
  endtask

  task automatic test_back_to_back();
    logic        tw [7];
    logic [9:0]  ta [7];
    logic [31:0] td [7];
    exp_t        e;
    int          cyc, last, ndone;
    tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ta = '{10'h3FC, 10'h3FC, 10'h3FC, 10'h3FC, 10'h000, 10'h3FC, 10'h3FC};
    td = '{32'hA5A51111, 32'h0, 32'h0BADCAFE, 32'h0, 32'h0, 32'h77778888, 32'h0};
    top_val0 = 32'h0;
    set0(tw[0], ta[0], td[0]);
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 7 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 === 1'b1) begin
        checks++;
        if (cyc !== ((ndone == 0) ? 2 : last + 3)) begin
          errors++;
          $display("FAIL b2b spacing[%0d]: got cycle %0d want %0d", ndone, cyc,
                   (ndone == 0) ? 2 : last + 3);
        end
        e = sb0.pop_front();
        checks++;
        if (rdata0 !== e.rdata || err0 !== 1'b0) begin
          errors++;
          $display("FAIL b2b data[%0d]: got %h/%b want %h/0", ndone, rdata0, err0, e.rdata);
        end
        ndone++;
        last = cyc;
        if (ndone < 7) set0(tw[ndone], ta[ndone], td[ndone]);
        else req0 = 1'b0;
      end
    end
    checks++;
    if (ndone !== 7) begin
      errors++;
      $display("FAIL b2b timeout: got %0d dones want 7", ndone);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    last_rd = 32'h0; last_rd0 = 32'h0; top_val0 = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    test_reset();
    test_word_rw();
    test_byte_write();
    test_zero_be();
    test_reset_in_access();
    test_align();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
